// File: rtl/volume_display_pkg.sv
// Shared types and constants for the volume meter display: peak FSM states,
// active-low segment codes, anode one-hot patterns and a small BCD helper.
package volume_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } peak_state_t;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Splits a value of at most 99 into {tens, ones} by trial subtraction.
    function automatic logic [7:0] to_bcd(input logic [6:0] value);
        logic [3:0] tens;
        logic [6:0] rest;
        tens = 4'd0;
        rest = value;
        for (int k = 9; k >= 1; k--) begin
            if (tens == 4'd0 && value >= 7'(10 * k)) begin
                tens = 4'(k);
                rest = value - 7'(10 * k);
            end
        end
        return {tens, 4'(rest)};
    endfunction

endpackage

// File: rtl/seg7_digit_decoder.sv
// One BCD digit to active-low 7-segment pattern {a,b,c,d,e,f,g}; a blank flag
// or an out-of-range code turns every segment off.
module seg7_digit_decoder
    import volume_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/volume_meter_display.sv
// Volume meter: clamped level register, peak hold/decay FSM, LED bar with a
// peak marker and a 4-digit multiplexed 7-segment readout (level | peak).
module volume_meter_display
    import volume_display_pkg::*;
#(
    parameter int LEVEL_W        = 4,
    parameter int MAX_LEVEL      = 15,
    parameter int REFRESH_DIV    = 100000,
    parameter int PEAK_HOLD_CYC  = 50000000,
    parameter int PEAK_DECAY_CYC = 10000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LEVEL_W-1:0]   level_in,
    input  logic                 peak_clr,
    output logic [MAX_LEVEL-1:0] led,
    output logic [3:0]           an,
    output logic [6:0]           seg,
    output logic [LEVEL_W-1:0]   peak_level
);

    localparam int REF_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int TIMER_MAX = (PEAK_HOLD_CYC > PEAK_DECAY_CYC) ? PEAK_HOLD_CYC : PEAK_DECAY_CYC;
    localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);
    localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(PEAK_HOLD_CYC - 1);
    localparam logic [TIMER_W-1:0] DECAY_LAST = TIMER_W'(PEAK_DECAY_CYC - 1);
    localparam logic [REF_W-1:0]   REF_LAST   = REF_W'(REFRESH_DIV - 1);

    logic [LEVEL_W-1:0]   lvl_q;
    logic [LEVEL_W-1:0]   peak, peak_next;
    logic [TIMER_W-1:0]   timer, timer_next;
    peak_state_t          state, state_next;
    logic [REF_W-1:0]     refresh_cnt;
    logic [1:0]           digit_sel;
    logic [MAX_LEVEL-1:0] led_next;
    logic [7:0]           lvl_bcd, peak_bcd;
    logic [3:0]           dig_bcd;
    logic                 dig_blank;
    logic [3:0]           an_next;
    logic [6:0]           seg_next;

    // Peak FSM state register, plus the clamped input stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_q <= '0;
            state <= IDLE;
            peak  <= '0;
            timer <= '0;
        end else begin
            lvl_q <= (level_in > LEVEL_MAX) ? LEVEL_MAX : level_in;
            state <= state_next;
            peak  <= peak_next;
            timer <= timer_next;
        end
    end

    // Capture outranks hold expiry and decrements, so a rising level always wins.
    always_comb begin
        state_next = state;
        peak_next  = peak;
        timer_next = timer;
        if (lvl_q >= peak || peak_clr) begin
            peak_next  = lvl_q;
            timer_next = '0;
            state_next = (lvl_q != '0) ? HOLD : IDLE;
        end else begin
            case (state)
                IDLE: begin
                end
                HOLD: begin
                    if (timer == HOLD_LAST) begin
                        state_next = DECAY;
                        timer_next = '0;
                    end else begin
                        timer_next = timer + TIMER_W'(1);
                    end
                end
                DECAY: begin
                    if (timer == DECAY_LAST) begin
                        peak_next  = peak - LEVEL_W'(1);
                        timer_next = '0;
                        if (peak == LEVEL_W'(1)) state_next = IDLE;
                    end else begin
                        timer_next = timer + TIMER_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Output decode: LED bar with peak marker and the digit for the current slot.
    always_comb begin
        led_next = '0;
        for (int i = 0; i < MAX_LEVEL; i++) begin
            led_next[i] = (LEVEL_W'(i) < lvl_q) ||
                          (peak > lvl_q && LEVEL_W'(i) == peak - LEVEL_W'(1));
        end
        lvl_bcd   = to_bcd(7'(lvl_q));
        peak_bcd  = to_bcd(7'(peak));
        dig_bcd   = lvl_bcd[3:0];
        dig_blank = 1'b0;
        an_next   = AN_DIG0;
        case (digit_sel)
            2'd0: begin
                dig_bcd = lvl_bcd[3:0];
                an_next = AN_DIG0;
            end
            2'd1: begin
                dig_bcd   = lvl_bcd[7:4];
                dig_blank = (lvl_bcd[7:4] == 4'd0);
                an_next   = AN_DIG1;
            end
            2'd2: begin
                dig_bcd = peak_bcd[3:0];
                an_next = AN_DIG2;
            end
            default: begin
                dig_bcd   = peak_bcd[7:4];
                dig_blank = (peak_bcd[7:4] == 4'd0);
                an_next   = AN_DIG3;
            end
        endcase
    end

    seg7_digit_decoder u_decoder (
        .bcd   (dig_bcd),
        .blank (dig_blank),
        .seg   (seg_next)
    );

    // Scan timing and registered display outputs; an and seg share one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_sel   <= 2'd0;
            led         <= '0;
            an          <= AN_OFF;
            seg         <= SEG_BLANK;
        end else begin
            if (refresh_cnt == REF_LAST) begin
                refresh_cnt <= '0;
                digit_sel   <= digit_sel + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + REF_W'(1);
            end
            led <= led_next;
            an  <= an_next;
            seg <= seg_next;
        end
    end

    assign peak_level = peak;

endmodule

// File: tb/tb_volume_meter_display.sv
// Directed bench for volume_meter_display with short refresh/hold/decay
// periods; expected values are hand-derived edge by edge.
module tb_volume_meter_display;

    logic        clk;
    logic        rst_n;
    logic [3:0]  level_in;
    logic        peak_clr;
    logic [14:0] led;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [3:0]  peak_level;

    int checks = 0;
    int errors = 0;

    volume_meter_display #(
        .LEVEL_W        (4),
        .MAX_LEVEL      (15),
        .REFRESH_DIV    (4),
        .PEAK_HOLD_CYC  (8),
        .PEAK_DECAY_CYC (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .level_in   (level_in),
        .peak_clr   (peak_clr),
        .led        (led),
        .an         (an),
        .seg        (seg),
        .peak_level (peak_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] lvl, input logic clr, input int cycles);
        level_in = lvl;
        peak_clr = clr;
        repeat (cycles) tick();
        peak_clr = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for a digit slot, then checks its anode and segments.
    task automatic waitAnode(input string tag, input logic [3:0] target, input logic [6:0] seg_exp);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (an !== target && n < 20);
        checkOutput({tag, "_an"}, 32'(an), 32'(target));
        checkOutput({tag, "_seg"}, 32'(seg), 32'(seg_exp));
    endtask

    initial begin
        rst_n    = 1'b0;
        level_in = 4'd7;
        peak_clr = 1'b0;

        repeat (3) tick();
        checkOutput("rst_led",  32'(led), 32'h0);
        checkOutput("rst_an",   32'(an), 32'hF);
        checkOutput("rst_seg",  32'(seg), 32'h7F);
        checkOutput("rst_peak", 32'(peak_level), 32'h0);
        rst_n = 1'b1;
        applyStimulus(4'd7, 1'b0, 2);
        checkOutput("rel_led",  32'(led), 32'h007F);
        checkOutput("rel_peak", 32'(peak_level), 32'd7);

        applyStimulus(4'd5, 1'b0, 1);
        applyStimulus(4'd5, 1'b1, 1);
        applyStimulus(4'd5, 1'b0, 1);
        checkOutput("lvl5_led",  32'(led), 32'h001F);
        checkOutput("lvl5_peak", 32'(peak_level), 32'd5);
        waitAnode("lvl5_d0", 4'b1110, 7'b0100100);
        waitAnode("lvl5_d1", 4'b1101, 7'b1111111);
        waitAnode("lvl5_d2", 4'b1011, 7'b0100100);
        waitAnode("lvl5_d3", 4'b0111, 7'b1111111);

        applyStimulus(4'd15, 1'b0, 2);
        checkOutput("lvl15_led",  32'(led), 32'h7FFF);
        checkOutput("lvl15_peak", 32'(peak_level), 32'd15);
        waitAnode("lvl15_d1", 4'b1101, 7'b1001111);
        waitAnode("lvl15_d0", 4'b1110, 7'b0100100);
        applyStimulus(4'd13, 1'b0, 2);
        waitAnode("lvl13_d1", 4'b1101, 7'b1001111);
        waitAnode("lvl13_d0", 4'b1110, 7'b0000110);

        applyStimulus(4'd12, 1'b0, 1);
        applyStimulus(4'd3, 1'b1, 1);
        checkOutput("hold_start", 32'(peak_level), 32'd12);
        applyStimulus(4'd3, 1'b0, 11);
        checkOutput("hold_end", 32'(peak_level), 32'd12);
        applyStimulus(4'd3, 1'b0, 1);
        checkOutput("decay_first", 32'(peak_level), 32'd11);
        applyStimulus(4'd3, 1'b0, 1);
        checkOutput("decay_marker", 32'(led), 32'h0407);
        applyStimulus(4'd3, 1'b0, 3);
        checkOutput("decay_p10", 32'(peak_level), 32'd10);
        for (int k = 3; k <= 9; k++) begin
            applyStimulus(4'd3, 1'b0, 4);
            checkOutput($sformatf("decay_p%0d", 12 - k), 32'(peak_level), 32'(12 - k));
        end
        applyStimulus(4'd3, 1'b0, 3);
        checkOutput("floor_peak", 32'(peak_level), 32'd3);
        checkOutput("floor_led",  32'(led), 32'h0007);

        applyStimulus(4'd9, 1'b0, 1);
        applyStimulus(4'd0, 1'b0, 1);
        applyStimulus(4'd0, 1'b0, 10);
        applyStimulus(4'd11, 1'b0, 1);
        checkOutput("cap_before", 32'(peak_level), 32'd9);
        applyStimulus(4'd11, 1'b0, 1);
        checkOutput("cap_wins", 32'(peak_level), 32'd11);
        waitAnode("cap_d3", 4'b0111, 7'b1001111);
        waitAnode("cap_d2", 4'b1011, 7'b1001111);

        applyStimulus(4'd0, 1'b0, 1);
        applyStimulus(4'd0, 1'b1, 1);
        checkOutput("clr_peak", 32'(peak_level), 32'd0);
        applyStimulus(4'd0, 1'b0, 1);
        checkOutput("clr_led", 32'(led), 32'h0);
        waitAnode("clr_d2", 4'b1011, 7'b0000001);
        waitAnode("clr_d3", 4'b0111, 7'b1111111);

        applyStimulus(4'd1, 1'b0, 1);
        applyStimulus(4'd0, 1'b0, 1);
        applyStimulus(4'd0, 1'b0, 1);
        checkOutput("p1_marker", 32'(led), 32'h0001);
        applyStimulus(4'd0, 1'b0, 10);
        checkOutput("p1_hold", 32'(peak_level), 32'd1);
        applyStimulus(4'd0, 1'b0, 1);
        checkOutput("p1_to_zero", 32'(peak_level), 32'd0);
        applyStimulus(4'd0, 1'b0, 1);
        checkOutput("p1_led_off", 32'(led), 32'h0);

        applyStimulus(4'd9, 1'b0, 1);
        applyStimulus(4'd0, 1'b0, 1);
        applyStimulus(4'd0, 1'b0, 10);
        checkOutput("mid_peak", 32'(peak_level), 32'd9);
        rst_n = 1'b0;
        applyStimulus(4'd0, 1'b0, 1);
        checkOutput("mid_rst_peak", 32'(peak_level), 32'd0);
        checkOutput("mid_rst_an",   32'(an), 32'hF);
        checkOutput("mid_rst_seg",  32'(seg), 32'h7F);
        checkOutput("mid_rst_led",  32'(led), 32'h0);
        rst_n = 1'b1;
        applyStimulus(4'd0, 1'b0, 1);
        checkOutput("post_an0",  32'(an), 32'hE);
        checkOutput("post_seg0", 32'(seg), 32'h01);
        applyStimulus(4'd0, 1'b0, 3);
        checkOutput("post_an0_end", 32'(an), 32'hE);
        applyStimulus(4'd0, 1'b0, 1);
        checkOutput("post_an1", 32'(an), 32'hD);
        applyStimulus(4'd0, 1'b0, 30);
        checkOutput("post_peak", 32'(peak_level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
